// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   state_t : fetch FSM encoding (IDLE/REQ/HOLD/SETTLE, 2 bits)
//   PC_INC  : increment applied to the PC on every sequential fetch
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        HOLD   = 2'd2,
        SETTLE = 2'd3
    } state_t;

    localparam int unsigned PC_INC = 1;

endpackage : fetch_pkg

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch sequencer's PC, instruction-memory and decode signals.
//   PC side     : pc_counter (to fetch), pc_data/pc_offset/pc_load (from fetch)
//   memory side : mem_req/mem_addr (from fetch), mem_ack/mem_rdata (to fetch)
//   execute     : branch_taken/branch_target (to fetch)
//   decode side : instr/instr_valid (from fetch), instr_ready (to fetch)
// master = fetch unit view, slave = environment view.
interface fetch_unit_if #(
    parameter int unsigned word_size = 16,
    parameter int unsigned mem_size  = 8
) ();

    logic [word_size-1:0] pc_counter;
    logic [word_size-1:0] pc_data;
    logic                 pc_offset;
    logic                 pc_load;

    logic                 mem_req;
    logic [mem_size-1:0]  mem_addr;
    logic                 mem_ack;
    logic [word_size-1:0] mem_rdata;

    logic                 branch_taken;
    logic [word_size-1:0] branch_target;

    logic [word_size-1:0] instr;
    logic                 instr_valid;
    logic                 instr_ready;

    modport master (
        input  pc_counter,
        output pc_data,
        output pc_offset,
        output pc_load,
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        input  branch_taken,
        input  branch_target,
        output instr,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        output pc_counter,
        input  pc_data,
        input  pc_offset,
        input  pc_load,
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        output branch_taken,
        output branch_target,
        input  instr,
        input  instr_valid,
        output instr_ready
    );

endinterface : fetch_unit_if

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer.
// Drives the PC (increment / branch load), fetches the word at the current PC
// over a req/ack handshake and hands it to decode over valid/ready.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : fetch_unit_if.master (PC, instruction memory, branch, decode)
// All outputs are registered except mem_addr, which follows pc_counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned word_size = 16,
    parameter int unsigned mem_size  = 8
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    state_t               state_q,       state_d;
    logic [word_size-1:0] pc_data_q,     pc_data_d;
    logic [word_size-1:0] instr_q,       instr_d;
    logic                 instr_valid_q, instr_valid_d;
    logic                 pc_offset_q,   pc_offset_d;
    logic                 pc_load_q,     pc_load_d;
    logic                 mem_req_q,     mem_req_d;

    // Only the low PC bits address instruction memory.
    logic unused_pc_hi;
    assign unused_pc_hi = ^bus.pc_counter[word_size-1:mem_size];

    // Next-state and next-output logic; branch redirect overrides everything.
    always_comb begin
        state_d       = state_q;
        pc_data_d     = pc_data_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        mem_req_d     = mem_req_q;
        pc_offset_d   = 1'b0;
        pc_load_d     = 1'b0;

        if (bus.branch_taken) begin
            // Any same-cycle ack is dropped: its data is never captured.
            state_d       = SETTLE;
            pc_data_d     = bus.branch_target;
            pc_load_d     = 1'b1;
            instr_valid_d = 1'b0;
            mem_req_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = REQ;
                    mem_req_d = 1'b1;
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        state_d       = HOLD;
                        instr_d       = bus.mem_rdata;
                        instr_valid_d = 1'b1;
                        pc_data_d     = word_size'(PC_INC);
                        pc_offset_d   = 1'b1;
                        mem_req_d     = 1'b0;
                    end else begin
                        mem_req_d = 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.instr_ready) begin
                        state_d       = REQ;
                        instr_valid_d = 1'b0;
                        mem_req_d     = 1'b1;
                    end
                end
                SETTLE: begin
                    // First SETTLE cycle carries the load strobe; the PC holds
                    // the target only after it, so request one cycle later.
                    if (!pc_load_q) begin
                        state_d   = REQ;
                        mem_req_d = 1'b1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            pc_data_q     <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            pc_offset_q   <= 1'b0;
            pc_load_q     <= 1'b0;
            mem_req_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_data_q     <= pc_data_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            pc_offset_q   <= pc_offset_d;
            pc_load_q     <= pc_load_d;
            mem_req_q     <= mem_req_d;
        end
    end

    assign bus.pc_data     = pc_data_q;
    assign bus.pc_offset   = pc_offset_q;
    assign bus.pc_load     = pc_load_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = bus.pc_counter[mem_size-1:0];
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a PC model and a wait-state memory model.
module tb_fetch_unit;

    logic clk;
    logic rst;

    fetch_unit_if #(.word_size(16), .mem_size(8)) bus ();

    fetch_unit #(.word_size(16), .mem_size(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks  = 0;
    int          n_pass    = 0;
    logic [15:0] pc        = 16'h0000;
    bit          mem_en    = 1'b0;
    int          ack_delay = 0;
    int          wait_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock: PC absorbs the strobes of the ending cycle, then the memory
    // model decides the ack for the next edge. Sampling point is #1 after edge.
    task automatic cycle();
        logic        off;
        logic        ld;
        logic [15:0] d;
        off = bus.pc_offset;
        ld  = bus.pc_load;
        d   = bus.pc_data;
        @(posedge clk);
        #1;
        if (rst) begin
            if (ld)       pc = d;
            else if (off) pc = pc + d;
        end
        bus.pc_counter = pc;
        if (mem_en && bus.mem_req) begin
            if (wait_cnt == ack_delay) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 16'h1000 + 16'(bus.mem_addr);
                wait_cnt      = 0;
            end else begin
                bus.mem_ack   = 1'b0;
                wait_cnt      = wait_cnt + 1;
            end
        end else begin
            bus.mem_ack = 1'b0;
            wait_cnt    = 0;
        end
    endtask

    initial begin
        rst               = 1'b1;
        bus.pc_counter    = 16'h0000;
        bus.mem_ack       = 1'b0;
        bus.mem_rdata     = 16'h0000;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 16'h0000;
        bus.instr_ready   = 1'b0;
        #2 rst = 1'b0;

        // Reset held for three cycles
        repeat (3) cycle();
        chk("rst_mem_req",     32'(bus.mem_req),     32'd0);
        chk("rst_pc_offset",   32'(bus.pc_offset),   32'd0);
        chk("rst_pc_load",     32'(bus.pc_load),     32'd0);
        chk("rst_pc_data",     32'(bus.pc_data),     32'd0);
        chk("rst_instr",       32'(bus.instr),       32'd0);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_mem_addr",    32'(bus.mem_addr),    32'd0);

        // Release: one IDLE cycle, then the first request at address 0
        rst = 1'b1;
        #1;
        chk("idle_mem_req", 32'(bus.mem_req), 32'd0);
        mem_en          = 1'b1;
        ack_delay       = 0;
        bus.instr_ready = 1'b1;
        cycle();
        chk("start_mem_req",  32'(bus.mem_req),  32'd1);
        chk("start_mem_addr", 32'(bus.mem_addr), 32'h00);

        // Zero-wait stream, one instruction every two cycles
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stream_instr",     32'(bus.instr),       32'h1000 + 32'(k));
            chk("stream_valid",     32'(bus.instr_valid), 32'd1);
            chk("stream_pc_offset", 32'(bus.pc_offset),   32'd1);
            chk("stream_pc_data",   32'(bus.pc_data),     32'd1);
            chk("stream_pc_load",   32'(bus.pc_load),     32'd0);
            chk("stream_req_low",   32'(bus.mem_req),     32'd0);
            if (k == 2) ack_delay = 3;
            cycle();
            chk("stream_req",       32'(bus.mem_req),     32'd1);
            chk("stream_addr",      32'(bus.mem_addr),    32'(k + 1));
            chk("stream_off_pulse", 32'(bus.pc_offset),   32'd0);
            chk("stream_valid_low", 32'(bus.instr_valid), 32'd0);
        end

        // Three wait states: request held four cycles in total
        for (int w = 0; w < 3; w++) begin
            cycle();
            chk("wait_req",       32'(bus.mem_req),     32'd1);
            chk("wait_addr",      32'(bus.mem_addr),    32'h03);
            chk("wait_pc_offset", 32'(bus.pc_offset),   32'd0);
            chk("wait_pc_load",   32'(bus.pc_load),     32'd0);
            chk("wait_valid",     32'(bus.instr_valid), 32'd0);
        end
        ack_delay       = 0;
        bus.instr_ready = 1'b0;
        cycle();
        chk("wait_instr",     32'(bus.instr),       32'h1003);
        chk("wait_valid_hi",  32'(bus.instr_valid), 32'd1);
        chk("wait_pc_offset", 32'(bus.pc_offset),   32'd1);

        // Decoder backpressure for five cycles
        for (int b = 0; b < 5; b++) begin
            cycle();
            chk("bp_instr",     32'(bus.instr),       32'h1003);
            chk("bp_valid",     32'(bus.instr_valid), 32'd1);
            chk("bp_mem_req",   32'(bus.mem_req),     32'd0);
            chk("bp_pc_offset", 32'(bus.pc_offset),   32'd0);
        end
        bus.instr_ready = 1'b1;
        cycle();
        chk("bp_release_valid", 32'(bus.instr_valid), 32'd0);
        chk("bp_release_req",   32'(bus.mem_req),     32'd1);
        chk("bp_release_addr",  32'(bus.mem_addr),    32'h04);
        bus.instr_ready = 1'b0;
        cycle();
        chk("hold_instr", 32'(bus.instr),       32'h1004);
        chk("hold_valid", 32'(bus.instr_valid), 32'd1);

        // Branch while holding an instruction
        bus.branch_taken  = 1'b1;
        bus.branch_target = 16'h0040;
        cycle();
        bus.branch_taken  = 1'b0;
        chk("br_pc_load",   32'(bus.pc_load),     32'd1);
        chk("br_pc_data",   32'(bus.pc_data),     32'h0040);
        chk("br_valid",     32'(bus.instr_valid), 32'd0);
        chk("br_mem_req",   32'(bus.mem_req),     32'd0);
        chk("br_pc_offset", 32'(bus.pc_offset),   32'd0);
        cycle();
        chk("br_settle_load", 32'(bus.pc_load), 32'd0);
        chk("br_settle_req",  32'(bus.mem_req), 32'd0);
        cycle();
        chk("br_refetch_req",  32'(bus.mem_req),  32'd1);
        chk("br_refetch_addr", 32'(bus.mem_addr), 32'h40);

        // Branch on the same edge as a memory ack
        bus.branch_taken  = 1'b1;
        bus.branch_target = 16'h0080;
        chk("coinc_ack_armed", 32'(bus.mem_ack), 32'd1);
        cycle();
        bus.branch_taken  = 1'b0;
        chk("coinc_pc_load",   32'(bus.pc_load),     32'd1);
        chk("coinc_pc_data",   32'(bus.pc_data),     32'h0080);
        chk("coinc_pc_offset", 32'(bus.pc_offset),   32'd0);
        chk("coinc_instr",     32'(bus.instr),       32'h1004);
        chk("coinc_valid",     32'(bus.instr_valid), 32'd0);
        chk("coinc_mem_req",   32'(bus.mem_req),     32'd0);
        cycle();
        chk("coinc_settle_req", 32'(bus.mem_req), 32'd0);
        cycle();
        chk("coinc_refetch_req",  32'(bus.mem_req),  32'd1);
        chk("coinc_refetch_addr", 32'(bus.mem_addr), 32'h80);
        cycle();
        chk("coinc_instr_new", 32'(bus.instr),       32'h1080);
        chk("coinc_valid_new", 32'(bus.instr_valid), 32'd1);

        // Reset mid-operation clears outputs without waiting for a clock
        rst = 1'b0;
        #1;
        chk("mid_rst_mem_req",   32'(bus.mem_req),     32'd0);
        chk("mid_rst_pc_offset", 32'(bus.pc_offset),   32'd0);
        chk("mid_rst_pc_load",   32'(bus.pc_load),     32'd0);
        chk("mid_rst_pc_data",   32'(bus.pc_data),     32'd0);
        chk("mid_rst_instr",     32'(bus.instr),       32'd0);
        chk("mid_rst_valid",     32'(bus.instr_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fetch_unit
